// File: rtl/freq_sweep_ctrl.sv
// PLL frequency sweep controller: buttons/auto-sweep pick a ROM image,
// then sequence the PLL reconfig IP; also keeps elapsed-time counters.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   btn_up_i/down/auto  debounced button levels
//   start_auto_i      restart auto sweep from pos 0
//   pass_nz_i/fail_nz_i  tester status
//   pll_busy_i        reconfig IP busy
//   pll_*_o           one-cycle pulses to reconfig IP
//   rom_sel_o         current pos (ROM image)
//   recfg_o           reconfig in progress
//   auto_o            auto-sweep mode
//   mins_bcd_o        elapsed minutes, BCD
//   tenths_o          elapsed 0.1 s ticks
module freq_sweep_ctrl #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned NPOS     = 11,
  parameter int unsigned POS_INIT = 7,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned HOLDOFF  = 2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up_i,
  input  logic        btn_down_i,
  input  logic        btn_auto_i,
  input  logic        start_auto_i,
  input  logic        pass_nz_i,
  input  logic        fail_nz_i,
  input  logic        pll_busy_i,
  output logic        pll_write_from_rom_o,
  output logic        pll_reconfig_o,
  output logic        pll_reconfig_reset_o,
  output logic [3:0]  rom_sel_o,
  output logic        recfg_o,
  output logic        auto_o,
  output logic [15:0] mins_bcd_o,
  output logic [15:0] tenths_o
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] ARM  = 3'd3;
  localparam logic [2:0] RUN  = 3'd4;

  localparam longint unsigned MIN_CYC =
    64'(60) * 64'(CLK_HZ);
  localparam longint unsigned TEN_CYC =
    64'(CLK_HZ / 10);
  localparam int PW = $clog2(MIN_CYC);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int HW =
    (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [PW-1:0] TEN_LAST =
    PW'(TEN_CYC - 1);
  localparam logic [PW-1:0] MIN_LAST =
    PW'(MIN_CYC - 1);
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [WW-1:0] W_ONE = WW'(1);
  localparam logic [WW-1:0] W_LOAD = WW'(TIMEOUT);
  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [HW-1:0] H_LOAD = HW'(HOLDOFF);
  localparam logic [3:0] POS_MAX = 4'(NPOS - 1);
  localparam logic [3:0] POS_RST = 4'(POS_INIT);

  logic [2:0]    state;
  logic [3:0]    pos;
  logic          auto_q;
  logic [WW-1:0] wdog;
  logic [HW-1:0] holdoff;
  logic          up_q;
  logic          down_q;
  logic          auto_btn_q;
  logic          wr_p;
  logic          rc_p;
  logic          rs_p;
  logic [PW-1:0] pre_t;
  logic [PW-1:0] pre_m;
  logic [15:0]   tenths;
  logic [15:0]   mins;

  logic       up_e;
  logic       down_e;
  logic       auto_e;
  logic       accept;
  logic [3:0] pos_n;
  logic       auto_n;

  assign up_e   = btn_up_i   & ~up_q;
  assign down_e = btn_down_i & ~down_q;
  assign auto_e = btn_auto_i & ~auto_btn_q;

  always_comb begin
    accept = 1'b0;
    pos_n  = pos;
    auto_n = auto_q;
    if (state == IDLE) begin
      if (start_auto_i) begin
        accept = 1'b1;
        pos_n  = 4'd0;
        auto_n = 1'b1;
      end else if (auto_e && auto_q) begin
        accept = 1'b1;
        auto_n = 1'b0;
      end else if (auto_e) begin
        accept = 1'b1;
        pos_n  = 4'd0;
        auto_n = 1'b1;
      end else if (down_e && pos < POS_MAX) begin
        accept = 1'b1;
        pos_n  = pos + 4'd1;
        auto_n = 1'b0;
      end else if (up_e && pos != 4'd0) begin
        accept = 1'b1;
        pos_n  = pos - 4'd1;
        auto_n = 1'b0;
      end else if (auto_q && pass_nz_i && fail_nz_i
                   && holdoff == '0
                   && pos < POS_MAX) begin
        accept = 1'b1;
        pos_n  = pos + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pos        <= POS_RST;
      auto_q     <= 1'b0;
      wdog       <= '0;
      holdoff    <= '0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      auto_btn_q <= 1'b0;
      wr_p       <= 1'b0;
      rc_p       <= 1'b0;
      rs_p       <= 1'b0;
    end else begin
      up_q       <= btn_up_i;
      down_q     <= btn_down_i;
      auto_btn_q <= btn_auto_i;
      wr_p       <= 1'b0;
      rc_p       <= 1'b0;
      rs_p       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (holdoff != '0)
            holdoff <= holdoff - H_ONE;
          if (accept) begin
            pos    <= pos_n;
            auto_q <= auto_n;
            state  <= LOAD;
          end
        end
        LOAD: begin
          wr_p  <= 1'b1;
          state <= WAIT;
        end
        WAIT: state <= ARM;
        ARM: begin
          if (!pll_busy_i) begin
            rc_p  <= 1'b1;
            wdog  <= W_LOAD;
            state <= RUN;
          end
        end
        RUN: begin
          wdog <= wdog - W_ONE;
          // watchdog expiry wins over a same-cycle completion
          if (wdog == W_ONE) begin
            rs_p    <= 1'b1;
            holdoff <= H_LOAD;
            state   <= IDLE;
          end else if (!rc_p && !pll_busy_i) begin
            holdoff <= H_LOAD;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [15:0] bcd_inc(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // clearing on accept too keeps the timers at 0
  // for every cycle in which recfg_o reads 1
  logic clr;
  assign clr = (state != IDLE) | accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_t  <= '0;
      pre_m  <= '0;
      tenths <= '0;
      mins   <= '0;
    end else if (clr) begin
      pre_t  <= '0;
      pre_m  <= '0;
      tenths <= '0;
      mins   <= '0;
    end else begin
      if (pre_t == TEN_LAST) begin
        pre_t  <= '0;
        tenths <= tenths + 16'd1;
      end else begin
        pre_t <= pre_t + P_ONE;
      end
      if (pre_m == MIN_LAST) begin
        pre_m <= '0;
        mins  <= bcd_inc(mins);
      end else begin
        pre_m <= pre_m + P_ONE;
      end
    end
  end

  assign pll_write_from_rom_o = wr_p;
  assign pll_reconfig_o       = rc_p;
  assign pll_reconfig_reset_o = rs_p;
  assign rom_sel_o            = pos;
  assign recfg_o              = (state != IDLE);
  assign auto_o               = auto_q;
  assign mins_bcd_o           = mins;
  assign tenths_o             = tenths;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed bench for freq_sweep_ctrl
// (CLK_HZ=100, TIMEOUT=8, HOLDOFF=4).
module tb_freq_sweep_ctrl;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_up_i;
  logic        btn_down_i;
  logic        btn_auto_i;
  logic        start_auto_i;
  logic        pass_nz_i;
  logic        fail_nz_i;
  logic        pll_busy_i;
  logic        pll_write_from_rom_o;
  logic        pll_reconfig_o;
  logic        pll_reconfig_reset_o;
  logic [3:0]  rom_sel_o;
  logic        recfg_o;
  logic        auto_o;
  logic [15:0] mins_bcd_o;
  logic [15:0] tenths_o;

  int chk = 0;
  int pass_n = 0;

  int wr_at, rc_at, rs_at;
  int wr_n, rc_n, rs_n, rf_n;

  freq_sweep_ctrl #(
    .CLK_HZ(100),
    .NPOS(11),
    .POS_INIT(7),
    .TIMEOUT(8),
    .HOLDOFF(HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_up_i(btn_up_i),
    .btn_down_i(btn_down_i),
    .btn_auto_i(btn_auto_i),
    .start_auto_i(start_auto_i),
    .pass_nz_i(pass_nz_i),
    .fail_nz_i(fail_nz_i),
    .pll_busy_i(pll_busy_i),
    .pll_write_from_rom_o(pll_write_from_rom_o),
    .pll_reconfig_o(pll_reconfig_o),
    .pll_reconfig_reset_o(pll_reconfig_reset_o),
    .rom_sel_o(rom_sel_o),
    .recfg_o(recfg_o),
    .auto_o(auto_o),
    .mins_bcd_o(mins_bcd_o),
    .tenths_o(tenths_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // step n cycles; buttons are dropped after the
  // first cycle; records pulse positions/counts
  task automatic run_seq(input int n,
                         input bit busy_hold);
    wr_at = -1; rc_at = -1; rs_at = -1;
    wr_n = 0; rc_n = 0; rs_n = 0; rf_n = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (i == 1) begin
        btn_up_i = 0;
        btn_down_i = 0;
        btn_auto_i = 0;
        start_auto_i = 0;
      end
      if (pll_write_from_rom_o) begin
        if (wr_at < 0) wr_at = i;
        wr_n++;
      end
      if (pll_reconfig_o) begin
        if (rc_at < 0) rc_at = i;
        rc_n++;
        if (busy_hold) pll_busy_i = 1;
      end
      if (pll_reconfig_reset_o) begin
        if (rs_at < 0) rs_at = i;
        rs_n++;
        pll_busy_i = 0;
      end
      if (recfg_o) rf_n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    step();
    step();
    chk++;
    if (rom_sel_o !== 4'd7 || auto_o !== 1'b0
        || recfg_o !== 1'b0)
      $display("FAIL reset_state got pos=%0d auto=%b recfg=%b want 7/0/0",
               rom_sel_o, auto_o, recfg_o);
    else pass_n++;
    chk++;
    if ({pll_write_from_rom_o, pll_reconfig_o,
         pll_reconfig_reset_o} !== 3'b000
        || mins_bcd_o !== 16'h0 || tenths_o !== 16'd0)
      $display("FAIL reset_outs got pulses=%b%b%b mins=%h tenths=%0d want 0",
               pll_write_from_rom_o, pll_reconfig_o,
               pll_reconfig_reset_o, mins_bcd_o, tenths_o);
    else pass_n++;
    rst_n = 1;
    step();
  endtask

  task automatic test_btn_up();
    btn_up_i = 1;
    step();
    chk++;
    if (rom_sel_o !== 4'd6 || recfg_o !== 1'b1)
      $display("FAIL up_accept got pos=%0d recfg=%b want 6/1",
               rom_sel_o, recfg_o);
    else pass_n++;
    btn_up_i = 0;
    run_seq(9, 0);
    // write one cycle after pos change, reconfig two
    // cycles after write; recfg high 5 cycles total
    chk++;
    if (wr_at !== 1 || wr_n !== 1)
      $display("FAIL up_write got at=%0d n=%0d want 1/1",
               wr_at + 1, wr_n);
    else pass_n++;
    chk++;
    if (rc_at !== 3 || rc_n !== 1)
      $display("FAIL up_reconfig got at=%0d n=%0d want 3/1",
               rc_at + 1, rc_n);
    else pass_n++;
    chk++;
    if (rf_n + 1 !== 5 || rs_n !== 0)
      $display("FAIL up_recfg_len got %0d rst=%0d want 5/0",
               rf_n + 1, rs_n);
    else pass_n++;
  endtask

  task automatic test_watchdog();
    btn_up_i = 1;
    run_seq(16, 1);
    chk++;
    if (rc_at !== 4 || rs_at !== 12 || rs_n !== 1)
      $display("FAIL wdog_reset got rc=%0d rs=%0d n=%0d want 4/12/1",
               rc_at, rs_at, rs_n);
    else pass_n++;
    chk++;
    if (rf_n !== 11 || recfg_o !== 1'b0
        || rom_sel_o !== 4'd5)
      $display("FAIL wdog_idle got rf=%0d recfg=%b pos=%0d want 11/0/5",
               rf_n, recfg_o, rom_sel_o);
    else pass_n++;
    pll_busy_i = 0;
  endtask

  task automatic test_auto_sweep();
    int last_pos;
    int last_done;
    int steps;
    int cyc;
    bit prev_rf;
    pass_nz_i = 1;
    fail_nz_i = 1;
    start_auto_i = 1;
    step();
    start_auto_i = 0;
    chk++;
    if (rom_sel_o !== 4'd0 || auto_o !== 1'b1)
      $display("FAIL sweep_start got pos=%0d auto=%b want 0/1",
               rom_sel_o, auto_o);
    else pass_n++;
    last_pos = 0;
    last_done = 0;
    steps = 0;
    cyc = 0;
    prev_rf = recfg_o;
    while (!(rom_sel_o == 4'd10 && !recfg_o)
           && cyc < 400) begin
      step();
      cyc++;
      if (prev_rf && !recfg_o) last_done = cyc;
      if (int'(rom_sel_o) != last_pos) begin
        chk++;
        if (int'(rom_sel_o) !== last_pos + 1)
          $display("FAIL sweep_seq got %0d want %0d",
                   rom_sel_o, last_pos + 1);
        else pass_n++;
        chk++;
        if (cyc - last_done < HOLD)
          $display("FAIL sweep_holdoff got gap=%0d want >=%0d",
                   cyc - last_done, HOLD);
        else pass_n++;
        last_pos = int'(rom_sel_o);
        steps++;
      end
      prev_rf = recfg_o;
    end
    chk++;
    if (steps !== 10 || cyc >= 400)
      $display("FAIL sweep_steps got %0d cyc=%0d want 10",
               steps, cyc);
    else pass_n++;
    run_seq(40, 0);
    chk++;
    if (rf_n !== 0 || rom_sel_o !== 4'd10
        || auto_o !== 1'b1)
      $display("FAIL sweep_stop got rf=%0d pos=%0d auto=%b want 0/10/1",
               rf_n, rom_sel_o, auto_o);
    else pass_n++;
  endtask

  task automatic test_bounds();
    btn_down_i = 1;
    run_seq(10, 0);
    chk++;
    if (wr_n + rc_n + rs_n !== 0 || rf_n !== 0
        || rom_sel_o !== 4'd10 || auto_o !== 1'b1)
      $display("FAIL down_at_max got pulses=%0d rf=%0d pos=%0d auto=%b want 0/0/10/1",
               wr_n + rc_n + rs_n, rf_n, rom_sel_o, auto_o);
    else pass_n++;
    pass_nz_i = 0;
    fail_nz_i = 0;
    btn_auto_i = 1;
    run_seq(10, 0);
    chk++;
    if (auto_o !== 1'b0 || rom_sel_o !== 4'd10
        || rf_n !== 5)
      $display("FAIL auto_off got auto=%b pos=%0d rf=%0d want 0/10/5",
               auto_o, rom_sel_o, rf_n);
    else pass_n++;
    btn_auto_i = 1;
    run_seq(10, 0);
    chk++;
    if (auto_o !== 1'b1 || rom_sel_o !== 4'd0)
      $display("FAIL auto_on got auto=%b pos=%0d want 1/0",
               auto_o, rom_sel_o);
    else pass_n++;
    btn_up_i = 1;
    run_seq(10, 0);
    chk++;
    if (wr_n + rc_n + rs_n !== 0 || rf_n !== 0
        || rom_sel_o !== 4'd0 || auto_o !== 1'b1)
      $display("FAIL up_at_min got pulses=%0d rf=%0d pos=%0d auto=%b want 0/0/0/1",
               wr_n + rc_n + rs_n, rf_n, rom_sel_o, auto_o);
    else pass_n++;
  endtask

  task automatic test_same_cycle();
    btn_auto_i = 1;
    run_seq(10, 0);
    btn_down_i = 1;
    run_seq(10, 0);
    chk++;
    if (rom_sel_o !== 4'd1 || auto_o !== 1'b0)
      $display("FAIL down_step got pos=%0d auto=%b want 1/0",
               rom_sel_o, auto_o);
    else pass_n++;
    btn_auto_i = 1;
    btn_down_i = 1;
    run_seq(12, 0);
    chk++;
    if (rom_sel_o !== 4'd0 || auto_o !== 1'b1
        || rf_n !== 5)
      $display("FAIL same_cycle got pos=%0d auto=%b rf=%0d want 0/1/5",
               rom_sel_o, auto_o, rf_n);
    else pass_n++;
  endtask

  task automatic test_reset_mid();
    btn_down_i = 1;
    step();
    btn_down_i = 0;
    step();
    rst_n = 0;
    #1;
    chk++;
    if (recfg_o !== 1'b0 || rom_sel_o !== 4'd7
        || pll_write_from_rom_o !== 1'b0)
      $display("FAIL mid_reset got recfg=%b pos=%0d wr=%b want 0/7/0",
               recfg_o, rom_sel_o, pll_write_from_rom_o);
    else pass_n++;
    step();
    step();
    rst_n = 1;
    run_seq(12, 0);
    chk++;
    if (wr_n + rc_n + rs_n !== 0 || rf_n !== 0)
      $display("FAIL mid_reset_quiet got pulses=%0d rf=%0d want 0/0",
               wr_n + rc_n + rs_n, rf_n);
    else pass_n++;
  endtask

  task automatic test_timers();
    int zero_bad;
    int cyc;
    rst_n = 0;
    step();
    rst_n = 1;
    for (int i = 0; i < 5990; i++) step();
    chk++;
    if (tenths_o !== 16'd599 || mins_bcd_o !== 16'h0)
      $display("FAIL timer_5990 got tenths=%0d mins=%h want 599/0000",
               tenths_o, mins_bcd_o);
    else pass_n++;
    for (int i = 0; i < 10; i++) step();
    chk++;
    if (tenths_o !== 16'd600 || mins_bcd_o !== 16'h0001)
      $display("FAIL timer_6000 got tenths=%0d mins=%h want 600/0001",
               tenths_o, mins_bcd_o);
    else pass_n++;
    btn_down_i = 1;
    step();
    btn_down_i = 0;
    zero_bad = 0;
    cyc = 0;
    while (recfg_o && cyc < 50) begin
      if (tenths_o !== 16'd0 || mins_bcd_o !== 16'h0)
        zero_bad++;
      step();
      cyc++;
    end
    chk++;
    if (zero_bad !== 0 || cyc !== 5
        || rom_sel_o !== 4'd8)
      $display("FAIL timer_hold got bad=%0d len=%0d pos=%0d want 0/5/8",
               zero_bad, cyc, rom_sel_o);
    else pass_n++;
    for (int i = 0; i < 10; i++) step();
    chk++;
    if (tenths_o !== 16'd1 || mins_bcd_o !== 16'h0)
      $display("FAIL timer_restart got tenths=%0d mins=%h want 1/0000",
               tenths_o, mins_bcd_o);
    else pass_n++;
  endtask

  initial begin
    rst_n = 0;
    btn_up_i = 0;
    btn_down_i = 0;
    btn_auto_i = 0;
    start_auto_i = 0;
    pass_nz_i = 0;
    fail_nz_i = 0;
    pll_busy_i = 0;
    test_reset();
    test_btn_up();
    test_watchdog();
    test_auto_sweep();
    test_bounds();
    test_same_cycle();
    test_reset_mid();
    test_timers();
    $display("%0d/%0d checks passed", pass_n, chk);
    $finish;
  end

endmodule

// File: doc/freq_sweep_ctrl.md
FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50000000, clk frequency in Hz; sets the 0.1 s tick period and the 1 min period.
REQ-002 Parameter NPOS, default 11, number of PLL ROM images; pos range 0..NPOS-1, pos 0 = fastest.
REQ-003 Parameter POS_INIT, default 7, pos after reset.
REQ-004 Parameter TIMEOUT, default 1000, RUN-state watchdog in cycles.
REQ-005 Parameter HOLDOFF, default 2000000, cycles after reconfig completion during which auto-advance is inhibited.
REQ-006 clk  in  1  system clock, 50 MHz.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 btn_up_i, btn_down_i, btn_auto_i  in  1 each  debounced button levels, active-high.
REQ-009 start_auto_i  in  1  level request: restart auto sweep from pos 0.
REQ-010 pass_nz_i, fail_nz_i  in  1 each  tester passcount != 0, failcount != 0.
REQ-011 pll_busy_i  in  1  busy from the PLL reconfig IP.
REQ-012 pll_write_from_rom_o, pll_reconfig_o, pll_reconfig_reset_o  out  1 each  single-cycle pulses to the PLL reconfig IP.
REQ-013 rom_sel_o  out  4  current pos; selects the ROM image feeding rom_data_in.
REQ-014 recfg_o  out  1  high whenever state != IDLE; holds the memory tester in reset.
REQ-015 auto_o  out  1  auto-sweep mode active.
REQ-016 mins_bcd_o  out  16  elapsed minutes, 4 BCD digits.
REQ-017 tenths_o  out  16  elapsed 0.1 s ticks, binary.

Function
REQ-018 FSM states: IDLE, LOAD, WAIT, ARM, RUN.
REQ-019 IDLE: on an accepted request, update pos/auto, then go to LOAD.
REQ-020 LOAD: pulse pll_write_from_rom_o for 1 cycle, then go to WAIT.
REQ-021 WAIT: 1 cycle, then go to ARM.
REQ-022 ARM: stay while pll_busy_i=1; when pll_busy_i=0, pulse pll_reconfig_o for 1 cycle, load the watchdog with TIMEOUT, go to RUN.
REQ-023 RUN: decrement the watchdog each cycle.
REQ-024 RUN completion: if pll_reconfig_o=0 and pll_busy_i=0, go to IDLE; earliest is the 2nd RUN cycle.
REQ-025 RUN watchdog: if the watchdog equals 1, pulse pll_reconfig_reset_o and go to IDLE; this has priority over completion in the same cycle.
REQ-026 Edge detection: rising edge = current level 1 and previous-cycle level 0; previous levels are registered every cycle in all states.
REQ-027 Requests are accepted only in IDLE; edges and start_auto_i in other states are dropped.
REQ-028 IDLE priority, one request per cycle, highest first:
  (a) start_auto_i=1 -> pos=0, auto=1.
  (b) btn_auto edge with auto=1 -> auto=0, pos unchanged.
  (c) btn_auto edge with auto=0 -> pos=0, auto=1.
  (d) btn_down edge with pos<NPOS-1 -> pos+1, auto=0.
  (e) btn_up edge with pos>0 -> pos-1, auto=0.
  (f) auto-advance.
REQ-029 A down edge at pos=NPOS-1 or an up edge at pos=0 is no request: pos, auto and state are unchanged.
REQ-030 Auto-advance condition: auto=1, pass_nz_i=1, fail_nz_i=1, holdoff counter=0 and pos<NPOS-1; action: pos+1.
REQ-031 At pos=NPOS-1, auto-advance stops and auto stays 1.
REQ-032 The holdoff counter loads HOLDOFF on every RUN->IDLE transition, decrements to 0 in IDLE, and is 0 after reset.
REQ-033 Timers run only while recfg_o=0; while recfg_o=1, both prescalers, tenths_o and mins_bcd_o are held at 0.
REQ-034 tenths_o increments every CLK_HZ/10 cycles and wraps 0xFFFF->0.
REQ-035 mins_bcd_o increments every 60*CLK_HZ cycles as BCD; each digit wraps 9->0 with carry; 9999 wraps to 0000.
REQ-036 Prescaler widths shall hold 60*CLK_HZ-1; they are 32 bits at the default.

Reset
REQ-037 rst_n=0 asynchronously sets:
  - state=IDLE;
  - pos=POS_INIT;
  - auto_o=0;
  - all pulse outputs 0;
  - recfg_o=0;
  - mins_bcd_o=0, tenths_o=0;
  - prescalers, watchdog, holdoff and previous-button registers all 0.
REQ-038 Reset asserted mid-reconfig abandons the sequence; no pulse is issued after release until a new request is accepted.

Verification (CLK_HZ=100, TIMEOUT=8, HOLDOFF=4)
REQ-039 Power-up, then a btn_up edge with busy=0 -> rom_sel_o goes 7->6; write_from_rom pulses 1 cycle later, reconfig 2 cycles after that; recfg_o is high for 5 cycles in total.
REQ-040 Hold busy=1 for 8 cycles after the reconfig pulse -> pll_reconfig_reset_o pulses on the 8th RUN cycle; state returns to IDLE.
REQ-041 Pulse start_auto_i, then hold pass_nz=fail_nz=1 with busy=0 -> pos steps 0,1,...,10, each step at least HOLDOFF cycles after the prior completion; pos stays at 10 with auto_o=1.
REQ-042 At pos=0 give a btn_up edge; at pos=10 give a btn_down edge -> no pulses, state remains IDLE.
REQ-043 In IDLE, run 6000 cycles -> mins_bcd_o=0x0001 and tenths_o=600; then a btn_down edge -> both read 0 while recfg_o=1.
REQ-044 Same-cycle btn_auto edge (auto=0) and btn_down edge -> pos=0, auto_o=1; the down edge is discarded.
